// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared opcodes, status codes, FSM states and default widths
//               for the mini-CPU run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  localparam int c_CNT_W_DEF   = 16;
  localparam int c_IMEM_AW_DEF = 8;
  localparam int c_IW_DEF      = 16;
  localparam int c_RF_AW_DEF   = 2;
  localparam int c_RW_DEF      = 8;

  localparam logic [1:0] c_OP_IMEM = 2'd0;
  localparam logic [1:0] c_OP_REG  = 2'd1;
  localparam logic [1:0] c_OP_CLR  = 2'd2;
  localparam logic [1:0] c_OP_RUN  = 2'd3;

  localparam logic [1:0] c_STAT_NONE    = 2'd0;
  localparam logic [1:0] c_STAT_HALTED  = 2'd1;
  localparam logic [1:0] c_STAT_TIMEOUT = 2'd2;
  localparam logic [1:0] c_STAT_ABORTED = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_IMEM = 3'd1,
    S_WR_REG  = 3'd2,
    S_CLR     = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5
  } ctrl_state_e;

  function automatic ctrl_state_e op_to_state(input logic [1:0] op);
    ctrl_state_e st;
    case (op)
      c_OP_IMEM: st = S_WR_IMEM;
      c_OP_REG:  st = S_WR_REG;
      c_OP_CLR:  st = S_CLR;
      default:   st = S_RUN;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : run_cycle_counter
// Description : Saturating run-cycle counter with limit compare. count_o is
//               the cycle count including the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module run_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = w_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit means the run is unbounded.
  assign expired_o = (limit_i != '0) && (w_cnt_inc == limit_i);
  assign count_o   = w_cnt_inc;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Host command sequencer driving load/clear/run pins of the
//               8-bit mini CPU core; reports run status and cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = c_CNT_W_DEF,
  parameter int IMEM_AW = c_IMEM_AW_DEF,
  parameter int IW      = c_IW_DEF,
  parameter int RF_AW   = c_RF_AW_DEF,
  parameter int RW      = c_RW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [IW-1:0]      cmd_data,
  input  logic               abort,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic               cpu_imem_we,
  output logic [IMEM_AW-1:0] cpu_imem_addr,
  output logic [IW-1:0]      cpu_imem_wdata,
  output logic               cpu_rf_we,
  output logic [RF_AW-1:0]   cpu_rf_addr,
  output logic [RW-1:0]      cpu_rf_wdata,
  input  logic               cpu_halt,
  output logic               done,
  output logic [1:0]         status,
  output logic [CNT_W-1:0]   cycle_count
);

  ctrl_state_e        state_q;
  logic               ready_q;
  logic               en_q;
  logic               core_rst_q;
  logic               imem_we_q;
  logic               rf_we_q;
  logic               done_q;
  logic [1:0]         status_q;
  logic [CNT_W-1:0]   cycle_count_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [IW-1:0]      data_q;
  logic [CNT_W-1:0]   limit_q;

  logic               w_accept;
  logic               w_run_start;
  logic               w_expired;
  logic [CNT_W-1:0]   w_cnt;

  assign w_accept    = cmd_valid && ready_q;
  assign w_run_start = w_accept && (cmd_op == c_OP_RUN);

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_run_start),
    .en_i      (state_q == S_RUN),
    .limit_i   (limit_q),
    .expired_o (w_expired),
    .count_o   (w_cnt)
  );

  // Every core-facing pin is a flop updated alongside state_q, so nothing on
  // cmd_* reaches the core combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      en_q          <= 1'b0;
      core_rst_q    <= 1'b0;
      imem_we_q     <= 1'b0;
      rf_we_q       <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= c_STAT_NONE;
      cycle_count_q <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      limit_q       <= '0;
    end else begin
      core_rst_q <= 1'b0;
      imem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            addr_q     <= cmd_addr;
            data_q     <= cmd_data;
            ready_q    <= 1'b0;
            state_q    <= op_to_state(cmd_op);
            imem_we_q  <= (cmd_op == c_OP_IMEM);
            rf_we_q    <= (cmd_op == c_OP_REG);
            core_rst_q <= (cmd_op == c_OP_CLR);
            if (cmd_op == c_OP_RUN) begin
              en_q          <= 1'b1;
              limit_q       <= CNT_W'(cmd_data);
              status_q      <= c_STAT_NONE;
              cycle_count_q <= '0;
            end
          end
        end

        S_WR_IMEM, S_WR_REG, S_CLR: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end

        S_RUN: begin
          if (cpu_halt || abort || w_expired) begin
            state_q       <= S_DONE;
            en_q          <= 1'b0;
            done_q        <= 1'b1;
            cycle_count_q <= w_cnt;
            if (cpu_halt) begin
              status_q <= c_STAT_HALTED;
            end else if (abort) begin
              status_q <= c_STAT_ABORTED;
            end else begin
              status_q <= c_STAT_TIMEOUT;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready      = ready_q;
  assign cpu_en         = en_q;
  assign cpu_rst        = core_rst_q;
  assign cpu_imem_we    = imem_we_q;
  assign cpu_imem_addr  = addr_q;
  assign cpu_imem_wdata = data_q;
  assign cpu_rf_we      = rf_we_q;
  assign cpu_rf_addr    = addr_q[RF_AW-1:0];
  assign cpu_rf_wdata   = data_q[RW-1:0];
  assign done           = done_q;
  assign status         = status_q;
  assign cycle_count    = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Scoreboard bench for cpu_run_ctrl with directed command vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int K_IMEM = 0;
  localparam int K_REG  = 1;
  localparam int K_CLR  = 2;
  localparam int K_DONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        abort;
  logic        cpu_en;
  logic        cpu_rst;
  logic        cpu_imem_we;
  logic [7:0]  cpu_imem_addr;
  logic [15:0] cpu_imem_wdata;
  logic        cpu_rf_we;
  logic [1:0]  cpu_rf_addr;
  logic [7:0]  cpu_rf_wdata;
  logic        cpu_halt;
  logic        done;
  logic [1:0]  status;
  logic [15:0] cycle_count;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .abort          (abort),
    .cpu_en         (cpu_en),
    .cpu_rst        (cpu_rst),
    .cpu_imem_we    (cpu_imem_we),
    .cpu_imem_addr  (cpu_imem_addr),
    .cpu_imem_wdata (cpu_imem_wdata),
    .cpu_rf_we      (cpu_rf_we),
    .cpu_rf_addr    (cpu_rf_addr),
    .cpu_rf_wdata   (cpu_rf_wdata),
    .cpu_halt       (cpu_halt),
    .done           (done),
    .status         (status),
    .cycle_count    (cycle_count)
  );

  // kind: event type; a/d: address+data or status+cycle_count;
  // e: cycles since acceptance (writes) or cpu_en cycles since last done.
  typedef struct {
    int kind;
    int a;
    int d;
    int e;
  } ev_t;

  ev_t exp_q[$];
  ev_t act;
  ev_t ex;
  int  nvec    = 0;
  int  nfail   = 0;
  int  cyc     = 0;
  int  acc_cyc = 0;
  int  en_cnt  = 0;
  int  nstb;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (cpu_en) en_cnt++;
      nstb = int'(cpu_imem_we) + int'(cpu_rf_we) + int'(cpu_rst) + int'(done);
      if (nstb != 0) begin
        act.a = 0; act.d = 0; act.e = cyc - acc_cyc;
        if (nstb > 1) begin
          act.kind = 9;
        end else if (done) begin
          act.kind = K_DONE; act.a = int'(status); act.d = int'(cycle_count); act.e = en_cnt;
        end else if (cpu_rst) begin
          act.kind = K_CLR;
        end else if (cpu_rf_we) begin
          act.kind = K_REG; act.a = int'(cpu_rf_addr); act.d = int'(cpu_rf_wdata);
        end else begin
          act.kind = K_IMEM; act.a = int'(cpu_imem_addr); act.d = int'(cpu_imem_wdata);
        end
        if (done) en_cnt = 0;
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_event: got kind=%0d a=%0h d=%0h e=%0d, want no event",
                   act.kind, act.a, act.d, act.e);
        end else begin
          ex = exp_q.pop_front();
          if (act.kind != ex.kind || act.a != ex.a || act.d != ex.d || act.e != ex.e) begin
            nfail++;
            $display("FAIL event_kind%0d: got kind=%0d a=%0h d=%0h e=%0d, want kind=%0d a=%0h d=%0h e=%0d",
                     ex.kind, act.kind, act.a, act.d, act.e, ex.kind, ex.a, ex.d, ex.e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic push(input int k, input int a, input int d, input int e);
    ev_t v;
    v.kind = k; v.a = a; v.d = d; v.e = e;
    exp_q.push_back(v);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [15:0] d);
    int w = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    if (!cmd_ready) begin
      nvec++;
      nfail++;
      $display("FAIL ready_timeout: got cmd_ready=0 want 1");
    end else begin
      case (op)
        2'd0: push(K_IMEM, int'(a), int'(d), 1);
        2'd1: push(K_REG, int'(a[1:0]), int'(d[7:0]), 1);
        2'd2: push(K_CLR, 0, 0, 1);
        default: ;
      endcase
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Drives halt from run cycle hk onward, abort in run cycle ak, and leaves
  // the bench in the DONE cycle after run cycle 'stop'.
  task automatic run_case(input int lim, input int hk, input int ak,
                          input int st, input int cc, input int en, input int stop);
    push(K_DONE, st, cc, en);
    cpu_halt = (hk == 1);
    abort    = (ak == 1);
    send(2'd3, 8'h00, lim[15:0]);
    for (int k = 2; k <= stop; k++) begin
      tick();
      cpu_halt = (hk != 0 && k >= hk);
      abort    = (ak == k);
    end
    tick();
    cpu_halt = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 8'h00; cmd_data = 16'h0000;
    abort = 1'b0; cpu_halt = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_strobes", 64'({cpu_en, cpu_rst, cpu_imem_we, cpu_rf_we, done}), 64'd0);
    chk("rst_buses", {25'd0, cpu_imem_addr, cpu_imem_wdata, cpu_rf_addr, cpu_rf_wdata}, 64'd0);
    chk("rst_result", 64'({status, cycle_count}), 64'd0);
    rst = 1'b0;
    tick();

    send(2'd0, 8'h05, 16'hB107);
    send(2'd2, 8'h00, 16'h0000);
    send(2'd1, 8'h02, 16'h00A5);
    send(2'd0, 8'h00, 16'h1001);
    send(2'd0, 8'h01, 16'hF0FF);

    run_case(20, 0, 0, 2, 20, 20, 20);
    run_case(0, 6, 0, 1, 6, 6, 6);
    run_case(0, 0, 10, 3, 10, 10, 10);
    run_case(0, 1, 0, 1, 1, 1, 1);
    run_case(0, 4, 4, 1, 4, 4, 4);
    run_case(5, 5, 0, 1, 5, 5, 5);
    run_case(1, 0, 0, 2, 1, 1, 1);
    drain();
    chk("status_hold", 64'({status, cycle_count}), {46'd0, 2'd2, 16'd1});

    // abort outside a run must not disturb writes or idle
    abort = 1'b1;
    tick();
    send(2'd0, 8'h20, 16'h1234);
    tick();
    abort = 1'b0;
    drain();
    chk("abort_idle_ready", 64'(cmd_ready), 64'd1);

    // back-to-back writes with cmd_valid held
    cmd_op = 2'd0; cmd_addr = 8'h10; cmd_data = 16'h1111; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 10) begin tick(); k++; end
    push(K_IMEM, 'h10, 'h1111, 1);
    tick();
    cmd_addr = 8'h11; cmd_data = 16'h2222;
    k = 1;
    while (!cmd_ready && k < 10) begin tick(); k++; end
    chk("b2b_gap", 64'(k), 64'd2);
    push(K_IMEM, 'h11, 'h2222, 1);
    tick();
    cmd_valid = 1'b0;
    drain();

    // reset in the middle of an unlimited run
    send(2'd3, 8'h00, 16'h0000);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_en", 64'(cpu_en), 64'd0);
    chk("midrst_ready_done", 64'({cmd_ready, done}), 64'd2);
    rst = 1'b0;
    repeat (5) tick();
    chk("midrst_idle", 64'({cpu_en, cmd_ready}), 64'd1);

    // unlimited run past counter saturation
    run_case(0, 0, 65540, 3, 65535, 65540, 65540);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
